// File: rtl/alu_pkg.sv
// Shared opcode and flag definitions for the pipelined ALU (alu_core, alu_pipe).
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLL = 3'd5,
        OP_SRA = 3'd6,
        OP_ACC = 3'd7
    } op_e;

    // Bit positions inside the 4-bit {N, V, C, Z} flag vector
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and {N,V,C,Z} from operands, opcode and accumulator.
// Signed saturation of ADD/SUB/ACC is enabled by defining ALU_SAT_EN.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    input  logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] x_op;
    logic [WIDTH-1:0] y_op;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] raw;
    logic             carry;
    logic             ovf;

    // ACC reuses the adder with the accumulator as the first operand
    assign x_op  = (op == OP_ACC) ? acc : a;
    assign y_op  = (op == OP_ACC) ? a   : b;
    assign sum   = {1'b0, x_op} + {1'b0, y_op};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[SHW-1:0];

    always_comb begin
        raw   = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD, OP_ACC: begin
                raw   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
                ovf   = (x_op[WIDTH-1] == y_op[WIDTH-1]) && (sum[WIDTH-1] != x_op[WIDTH-1]);
            end
            OP_SUB: begin
                raw   = diff[WIDTH-1:0];
                carry = diff[WIDTH];
                ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  raw = a & b;
            OP_OR:   raw = a | b;
            OP_XOR:  raw = a ^ b;
            OP_SLL:  raw = a << shamt;
            OP_SRA:  raw = $unsigned($signed(a) >>> shamt);
            default: raw = '0;
        endcase
    end

    // Overflow direction always follows the sign of the first operand
`ifdef ALU_SAT_EN
    assign result = ovf ? (x_op[WIDTH-1] ? SAT_MIN : SAT_MAX) : raw;
`else
    assign result = raw;
`endif

    always_comb begin
        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_V] = ovf;
        flags[FLAG_C] = carry;
        flags[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready pipelined ALU with running accumulator and status flags.
// Define ALU_SAT_EN for signed saturation of ADD/SUB/ACC (implemented in alu_core).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic [WIDTH-1:0] acc
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic             s2_ready;
    logic             acc_beat;
    logic [WIDTH-1:0] acc_src;
    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign acc_beat = s1_valid && s2_ready && (s1_op == OP_ACC);

    // A clear coinciding with an ACC beat makes that beat start from zero
    assign acc_src = acc_clr ? '0 : acc;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a      (s1_a),
        .b      (s1_b),
        .op     (s1_op),
        .acc    (acc_src),
        .result (core_result),
        .flags  (core_flags)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_ADD;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_op <= op_e'(op);
            end
        end
    end

    // Output register holds while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                result <= core_result;
                flags  <= core_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (acc_beat) begin
            acc <= core_result;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (WIDTH=8); expectations follow ALU_SAT_EN.
module tb_alu_pipe;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic [WIDTH-1:0] acc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH (WIDTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .acc       (acc)
    );

    // Drive one beat from idle and return at the negedge after it reaches stage 2
    task automatic run_single(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
        acc_clr = 1'b0; out_ready = 1'b1;
        #12;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (result !== 8'h00) begin bad++; $display("[TB] FAIL reset_result got=%h want=00", result); end
        total++; if (flags !== 4'h0) begin bad++; $display("[TB] FAIL reset_flags got=%h want=0", flags); end
        total++; if (acc !== 8'h00) begin bad++; $display("[TB] FAIL reset_acc got=%h want=00", acc); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_add();
        logic [7:0] want_r;
        logic [3:0] want_f;
`ifdef ALU_SAT_EN
        want_r = 8'h7F; want_f = 4'b0100;
`else
        want_r = 8'h80; want_f = 4'b1100;
`endif
        @(negedge clk);
        op = 3'd0; a = 8'h7F; b = 8'h01; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_early_valid got=%b want=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL add_latency_valid got=%b want=1", out_valid); end
        total++; if (result !== want_r) begin bad++; $display("[TB] FAIL add_ovf_result got=%h want=%h", result, want_r); end
        total++; if (flags !== want_f) begin bad++; $display("[TB] FAIL add_ovf_flags got=%b want=%b", flags, want_f); end
        run_single(3'd0, 8'hFF, 8'h01);
        total++; if (result !== 8'h00) begin bad++; $display("[TB] FAIL add_carry_result got=%h want=00", result); end
        total++; if (flags !== 4'b0011) begin bad++; $display("[TB] FAIL add_carry_flags got=%b want=0011", flags); end
    endtask

    task automatic test_sub_logic();
        run_single(3'd1, 8'h05, 8'h07);
        total++; if (result !== 8'hFE) begin bad++; $display("[TB] FAIL sub_borrow_result got=%h want=fe", result); end
        total++; if (flags !== 4'b1010) begin bad++; $display("[TB] FAIL sub_borrow_flags got=%b want=1010", flags); end
        run_single(3'd1, 8'h07, 8'h07);
        total++; if (result !== 8'h00) begin bad++; $display("[TB] FAIL sub_zero_result got=%h want=00", result); end
        total++; if (flags !== 4'b0001) begin bad++; $display("[TB] FAIL sub_zero_flags got=%b want=0001", flags); end
        run_single(3'd2, 8'hF0, 8'h3C);
        total++; if (result !== 8'h30) begin bad++; $display("[TB] FAIL and_result got=%h want=30", result); end
        run_single(3'd3, 8'hF0, 8'h0C);
        total++; if (result !== 8'hFC) begin bad++; $display("[TB] FAIL or_result got=%h want=fc", result); end
        total++; if (flags !== 4'b1000) begin bad++; $display("[TB] FAIL or_flags got=%b want=1000", flags); end
        run_single(3'd4, 8'hAA, 8'hAA);
        total++; if (flags !== 4'b0001) begin bad++; $display("[TB] FAIL xor_zero_flags got=%b want=0001", flags); end
    endtask

    task automatic test_shift();
        run_single(3'd6, 8'h90, 8'h03);
        total++; if (result !== 8'hF2) begin bad++; $display("[TB] FAIL sra_result got=%h want=f2", result); end
        total++; if (flags !== 4'b1000) begin bad++; $display("[TB] FAIL sra_flags got=%b want=1000", flags); end
        run_single(3'd5, 8'h81, 8'h09);
        total++; if (result !== 8'h02) begin bad++; $display("[TB] FAIL sll_result got=%h want=02", result); end
    endtask

    task automatic test_acc();
        @(negedge clk);
        op = 3'd7; b = 8'hEE; a = 8'd3; in_valid = 1'b1;
        @(negedge clk);
        a = 8'd4;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL acc_early_valid got=%b want=0", out_valid); end
        @(negedge clk);
        a = 8'd5;
        total++; if (result !== 8'd3) begin bad++; $display("[TB] FAIL acc_first_result got=%0d want=3", result); end
        total++; if (acc !== 8'd3) begin bad++; $display("[TB] FAIL acc_first_acc got=%0d want=3", acc); end
        @(negedge clk);
        a = 8'd2;
        total++; if (result !== 8'd7) begin bad++; $display("[TB] FAIL acc_second_result got=%0d want=7", result); end
        @(negedge clk);
        in_valid = 1'b0; acc_clr = 1'b1;
        total++; if (result !== 8'd12) begin bad++; $display("[TB] FAIL acc_third_result got=%0d want=12", result); end
        total++; if (acc !== 8'd12) begin bad++; $display("[TB] FAIL acc_third_acc got=%0d want=12", acc); end
        @(negedge clk);
        acc_clr = 1'b0;
        total++; if (result !== 8'd2) begin bad++; $display("[TB] FAIL acc_clr_result got=%0d want=2", result); end
        total++; if (acc !== 8'd2) begin bad++; $display("[TB] FAIL acc_clr_acc got=%0d want=2", acc); end
        total++; if (flags !== 4'b0000) begin bad++; $display("[TB] FAIL acc_clr_flags got=%b want=0000", flags); end
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        total++; if (acc !== 8'd0) begin bad++; $display("[TB] FAIL acc_plain_clr got=%0d want=0", acc); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want [10];
        logic       pattern [4];
        logic       held;
        logic [7:0] held_r;
        logic [3:0] held_f;
        int         sent;
        int         got;
        int         cycle;
        pattern[0] = 1'b1; pattern[1] = 1'b0; pattern[2] = 1'b0; pattern[3] = 1'b1;
        for (int i = 0; i < 10; i++) want[i] = 8'(i * 5 + i * 3 + 1);
        sent = 0; got = 0; cycle = 0; held = 1'b0; held_r = '0; held_f = '0;
        while (got < 10 && cycle < 300) begin
            @(negedge clk);
            if (held) begin
                total++; if (out_valid !== 1'b1 || result !== held_r || flags !== held_f) begin
                    bad++; $display("[TB] FAIL stream_stall_stable got=%b/%h/%b want=1/%h/%b", out_valid, result, flags, held_r, held_f);
                end
            end
            out_ready = pattern[cycle % 4];
            op = 3'd0;
            in_valid = (sent < 10);
            a = 8'(sent * 5);
            b = 8'(sent * 3 + 1);
            #1;
            if (in_valid && in_ready) sent++;
            if (out_valid && out_ready) begin
                total++; if (result !== want[got]) begin bad++; $display("[TB] FAIL stream_result[%0d] got=%h want=%h", got, result, want[got]); end
                got++;
            end
            held   = out_valid && !out_ready;
            held_r = result;
            held_f = flags;
            cycle++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got !== 10) begin bad++; $display("[TB] FAIL stream_timeout got=%0d want=10", got); end
        @(negedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL stream_no_dup got=%b want=0", out_valid); end
    endtask

    task automatic test_reset_stall();
        @(negedge clk);
        out_ready = 1'b0; op = 3'd7; a = 8'd9; b = 8'd0; in_valid = 1'b1;
        @(negedge clk);
        op = 3'd0; a = 8'd2; b = 8'd2;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL stall_full got=%b/%b want=1/0", out_valid, in_ready); end
        total++; if (acc !== 8'd9) begin bad++; $display("[TB] FAIL stall_acc got=%0d want=9", acc); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_stall_valid got=%b want=0", out_valid); end
        total++; if (acc !== 8'd0) begin bad++; $display("[TB] FAIL rst_stall_acc got=%0d want=0", acc); end
        total++; if (result !== 8'd0 || flags !== 4'd0) begin bad++; $display("[TB] FAIL rst_stall_result got=%h/%b want=00/0000", result, flags); end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready got=%b want=1", in_ready); end
        op = 3'd0; a = 8'h10; b = 8'h20; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_dropped_beat got=%b want=0", out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || result !== 8'h30) begin bad++; $display("[TB] FAIL rst_first_beat got=%b/%h want=1/30", out_valid, result); end
    endtask

    initial begin
        $display("[TB] starting alu_pipe bench");
        test_reset();
        test_add();
        test_sub_logic();
        test_shift();
        test_acc();
        test_back_to_back();
        test_reset_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, two-stage pipelined successor to the team's combinational 3-bit-opcode ALU. Keeps opcodes 0–4 bit-compatible and adds shifts, a running accumulator, status flags and valid/ready handshakes on both sides. Sits between an operand-issue stage and a result writeback/consumer in the DSP datapath, sustaining one operation per cycle when unstalled.

## Interface
- `WIDTH`, 8, operand/result width in bits (≥4).
- `SHW`, `$clog2(WIDTH)`, shift-amount width (derived; not overridden).
- `clk` input 1: single clock; all state on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand beat valid.
- `in_ready` output 1: block accepts the beat this cycle.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B (low SHW bits = shift amount for shifts).
- `op` input 3: opcode.
- `acc_clr` input 1: single-cycle accumulator clear request.
- `out_valid` output 1: result beat valid.
- `out_ready` input 1: consumer accepts the result.
- `result` output WIDTH: result.
- `flags` output 4: {N, V, C, Z} for the result beat.
- `acc` output WIDTH: current accumulator value.

## Operation
- Opcodes: 0 ADD a+b; 1 SUB a−b; 2 AND; 3 OR; 4 XOR; 5 SLL a<<b[SHW-1:0]; 6 SRA a>>>b[SHW-1:0]; 7 ACC, result = acc+a (b ignored), acc updated to result.
- Stage 1 registers {a, b, op}. Stage 2 computes and registers {result, flags}, and updates acc for ACC.
- Arithmetic is computed at WIDTH+1 bits. C = carry-out for ADD/ACC; for SUB, C = borrow (a < b unsigned); 0 for other ops.
- V = signed overflow for ADD/SUB/ACC; 0 otherwise.
- Z = (result == 0). N = result[WIDTH-1].
- Handshake: `s2_ready = !out_valid | out_ready`; `in_ready = !s1_valid | s2_ready`. A beat transfers when valid & ready on that side.
- While `out_valid` is high and `out_ready` is low, `result`/`flags` stay stable.
- `acc_clr` is sampled every cycle. acc ← 0 on the next edge unless an ACC beat enters stage 2 in the same cycle; in that case acc ← a and result = a, with C/V computed as 0 + a.
- Reset (async, any time, including mid-stall): s1_valid = 0, out_valid = 0, result = 0, flags = 0, acc = 0; `in_ready` = 1 from the first cycle after release. In-flight beats are dropped.

## Timing
- Latency: a beat accepted at edge k appears with `out_valid` = 1 after edge k+2, with no stall.
- Throughput: 1 beat/cycle when `out_ready` is held high.
- Back-pressure: a single `out_ready` low stalls both stages. `in_ready` falls in the same cycle only if stage 1 is occupied.
- `acc` output is registered and reflects ACC beats from the cycle after they enter stage 2.
- No combinational path from `in_valid` to `out_valid`. `in_ready` depends combinationally on `out_ready`.

## Configuration
- `ALU_SAT_EN` defined: ADD, SUB and ACC saturate signed on overflow, clamping to 2^(WIDTH-1)−1 or −2^(WIDTH-1). V still reports the overflow; Z and N reflect the clamped value; acc stores the clamped value.
- `ALU_SAT_EN` undefined: two's-complement wrap; results are bit-identical to the legacy ALU for opcodes 0–4.

## Structure
- Package `alu_pkg`: opcode enum (OP_ADD … OP_ACC), flag bit indices (FLAG_Z=0, FLAG_C=1, FLAG_V=2, FLAG_N=3).
- Sub-module `alu_core`: purely combinational compute of {result, flags} from {a, b, op, acc}, including saturation. `alu_pipe` owns the registers, handshakes and accumulator.

## Test plan
- WIDTH=8, ADD 0x7F+0x01, no `ALU_SAT_EN` -> result 0x80, flags N=1 V=1 C=0 Z=0, two cycles after acceptance. With `ALU_SAT_EN` -> result 0x7F, V=1.
- SUB 0x05−0x07 -> result 0xFE, C=1 (borrow), N=1. SUB 0x07−0x07 -> result 0x00, Z=1.
- SRA a=0x90, b=0x03 -> 0xF2. SLL a=0x81, b=0x09 (shift amount 1) -> 0x02.
- ACC a=3,4,5 back-to-back -> results 3, 7, 12, acc=12. `acc_clr` in the same cycle the 4th ACC (a=2) enters stage 2 -> result 2, acc=2.
- Stream 10 ADD beats with `out_ready` toggling 1,0,0,1 -> no beat lost or duplicated, outputs stable while stalled, in-order results.
- Assert `rst_n` low while stalled with both stages full -> `out_valid` = 0, acc = 0 immediately. After release, the first beat returns after 2 cycles.
